lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Receive-side companion to the 32-bit LFSR pattern generator: consumes the word stream the generator emits (one new word per cycle, each word the generator register shifted by one bit), self-synchronises to it without knowing the seed, then reports word and bit errors. It sits at the far end of a link or loopback under test, typically in the UDM-observed test fabric of the NEXYS4_DDR build, with counters read out by the debug master.

## Interface
- LOCK_CNT, 8: consecutive predicted-word matches required to declare lock (1..255)
- UNLOCK_CNT, 4: consecutive word errors while locked that drop lock (1..255)
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- data_in  in  32  received generator word
- valid  in  1  data_in is sampled on this edge; gaps allowed, prediction advances only on valid
- clear  in  1  synchronous clear of err_cnt, bit_err_cnt, word_cnt
- locked  out  1  checker is in LOCKED state
- err  out  1  one-cycle pulse: last sampled word mismatched while locked
- err_cnt  out  32  words in error while locked, saturating
- bit_err_cnt  out  32  total mismatched bits while locked, saturating
- word_cnt  out  32  words checked while locked, saturating

## Operation
- step(x) = {x[30:0], x[31]^x[30]^x[29]^x[27]^x[25]^x[0]}; identical to the generator polynomial.
- States SEARCH, LOCKED. Reset: SEARCH, locked=0, err=0, all counters 0, match_cnt=0, miss_cnt=0, have_prev=0, prev=0, ref=0.
- SEARCH, on valid: match if have_prev && data_in == step(prev) && data_in != 0; match -> match_cnt+1, else match_cnt=0. prev<=data_in, have_prev<=1. When match_cnt reaches LOCK_CNT: go LOCKED, ref<=step(data_in), miss_cnt=0. No counter updates, err stays 0.
- All-zero word never counts as a match (lock-up state of the polynomial; step(0)=0 would false-lock). A repeated first word after generator reset is a normal mismatch and simply restarts the hunt.
- LOCKED, on valid: compare data_in to ref (free-running reference, never reloaded from data, so single errors do not propagate). ref<=step(ref); word_cnt+1. Mismatch -> err=1 next cycle, err_cnt+1, bit_err_cnt += popcount(data_in ^ ref), miss_cnt+1; match -> miss_cnt=0.
- When miss_cnt reaches UNLOCK_CNT: go SEARCH, match_cnt=0, prev<=data_in, have_prev=1 (the failing word seeds the new hunt).
- No valid: state, ref, prev, counters hold; err=0.
- Counters saturate at 0xFFFFFFFF; bit_err_cnt addition saturates rather than wraps.
- clear has priority over a simultaneous valid word: counters become 0 and that word is not counted; state/lock unaffected; err still reflects that word.

## Timing
- All outputs registered. Word sampled at edge N: err, counters, locked updated at edge N (visible cycle N+1).
- Minimum lock latency from first valid word: LOCK_CNT+1 valid words; locked high in the cycle after the (LOCK_CNT+1)-th word.
- Unlock: locked falls in the cycle after the UNLOCK_CNT-th consecutive bad word; that word is counted.
- rst mid-operation: immediate return to reset values regardless of valid/clear.
- Single-cycle critical path: 32-bit XOR + popcount + 32-bit saturating add; acceptable at board clock, no pipelining.

## Structure
- Package lfsr_pkg: LFSR width 32, tap constant, step function shared with the generator, state encoding for SEARCH/LOCKED.
- One sub-module: popcount32 (combinational 32-bit ones count, 6-bit result).
- Counters and FSM in lfsr_checker itself.

## Test plan
- Seed 0x00000001 stream (0x1, 0x3, 0x7, ...) continuous valid -> locked rises after 9th word, err never pulses, word_cnt increments 1 per word.
- Locked, flip bits 0 and 5 of one word -> single err pulse, err_cnt=1, bit_err_cnt=2, next word matches (no propagation), locked stays 1.
- Locked, 4 consecutive corrupted words -> err_cnt=4, locked falls after 4th; clean stream resumes -> relock after 8 further matches.
- Constant 0x00000000 input for 100 cycles -> locked stays 0; 0x80000000 followed by 0x00000001 counts one match only.
- Valid toggled every other cycle on a clean stream -> same lock and zero errors as continuous; clear asserted together with an erroneous word -> counters 0, err pulses, locked held.
- rst asserted while locked with err_cnt=3 -> all outputs 0 immediately, relock from scratch.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit LFSR pattern generator and checker:
// width, feedback taps, the one-step advance function and checker FSM states.
package lfsr_pkg;

    localparam int unsigned LfsrWidth = 32;

    // Feedback taps at bits 31, 30, 29, 27, 25 and 0.
    localparam logic [LfsrWidth-1:0] LfsrTaps = 32'hEA00_0001;

    typedef enum logic {
        StSearch = 1'b0,
        StLocked = 1'b1
    } state_e;

    function automatic logic [LfsrWidth-1:0] lfsr_step(input logic [LfsrWidth-1:0] x);
        return {x[LfsrWidth-2:0], ^(x & LfsrTaps)};
    endfunction

endpackage

// File: rtl/popcount32.sv
// Combinational ones count of a 32-bit word.
module popcount32 (
    input  logic [31:0] data_i,
    output logic [5:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < 32; i++) begin
            count_o = count_o + 6'(data_i[i]);
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 32-bit LFSR word stream: hunts for lock
// without knowing the seed, then counts word and bit errors against a free-running reference.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        valid,
    input  logic        clear,
    output logic        locked,
    output logic        err,
    output logic [31:0] err_cnt,
    output logic [31:0] bit_err_cnt,
    output logic [31:0] word_cnt
);

    localparam logic [7:0] LockCntW   = 8'(LOCK_CNT);
    localparam logic [7:0] UnlockCntW = 8'(UNLOCK_CNT);

    state_e      state_q, state_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic [7:0]  miss_cnt_q, miss_cnt_d;
    logic        have_prev_q, have_prev_d;
    logic [31:0] prev_q, prev_d;
    logic [31:0] ref_q, ref_d;
    logic        err_q, err_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [31:0] bit_err_cnt_q, bit_err_cnt_d;
    logic [31:0] word_cnt_q, word_cnt_d;

    logic [31:0] diff;
    logic [5:0]  diff_bits;
    logic [32:0] bit_sum;
    logic        search_match;
    logic        word_bad;

    assign diff = data_in ^ ref_q;

    popcount32 u_popcount (
        .data_i  (diff),
        .count_o (diff_bits)
    );

    assign bit_sum      = {1'b0, bit_err_cnt_q} + {27'd0, diff_bits};
    // An all-zero word is the polynomial's lock-up state and must never count as a match.
    assign search_match = have_prev_q && (data_in == lfsr_step(prev_q)) && (data_in != '0);
    assign word_bad     = (diff != '0);

    always_comb begin
        state_d       = state_q;
        match_cnt_d   = match_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        have_prev_d   = have_prev_q;
        prev_d        = prev_q;
        ref_d         = ref_q;
        err_d         = 1'b0;
        err_cnt_d     = err_cnt_q;
        bit_err_cnt_d = bit_err_cnt_q;
        word_cnt_d    = word_cnt_q;

        unique case (state_q)
            StSearch: begin
                if (valid) begin
                    prev_d      = data_in;
                    have_prev_d = 1'b1;
                    if (!search_match) begin
                        match_cnt_d = '0;
                    end else if (match_cnt_q + 8'd1 >= LockCntW) begin
                        state_d     = StLocked;
                        ref_d       = lfsr_step(data_in);
                        miss_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end
                end
            end
            StLocked: begin
                if (valid) begin
                    // Reference free-runs so a single bad word cannot corrupt later predictions.
                    ref_d      = lfsr_step(ref_q);
                    word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 32'd1;
                    if (word_bad) begin
                        err_d         = 1'b1;
                        err_cnt_d     = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 32'd1;
                        bit_err_cnt_d = bit_sum[32] ? '1 : bit_sum[31:0];
                        if (miss_cnt_q + 8'd1 >= UnlockCntW) begin
                            state_d     = StSearch;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            prev_d      = data_in;
                            have_prev_d = 1'b1;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 8'd1;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
            end
            default: state_d = StSearch;
        endcase

        if (clear) begin
            err_cnt_d     = '0;
            bit_err_cnt_d = '0;
            word_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StSearch;
            match_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            have_prev_q   <= 1'b0;
            prev_q        <= '0;
            ref_q         <= '0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
            bit_err_cnt_q <= '0;
            word_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            match_cnt_q   <= match_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            have_prev_q   <= have_prev_d;
            prev_q        <= prev_d;
            ref_q         <= ref_d;
            err_q         <= err_d;
            err_cnt_q     <= err_cnt_d;
            bit_err_cnt_q <= bit_err_cnt_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

    assign locked      = (state_q == StLocked);
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;
    assign bit_err_cnt = bit_err_cnt_q;
    assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: fixed vector table, directed corner sequences and a
// randomised stream, all checked against a behavioural model of the checker.
module tb_lfsr_checker;

    localparam int unsigned LockCnt   = 8;
    localparam int unsigned UnlockCnt = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        valid;
    logic        clear;
    logic        locked;
    logic        err;
    logic [31:0] err_cnt;
    logic [31:0] bit_err_cnt;
    logic [31:0] word_cnt;

    int checks = 0;
    int errors = 0;

    lfsr_checker #(
        .LOCK_CNT   (LockCnt),
        .UNLOCK_CNT (UnlockCnt)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .valid       (valid),
        .clear       (clear),
        .locked      (locked),
        .err         (err),
        .err_cnt     (err_cnt),
        .bit_err_cnt (bit_err_cnt),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic bit [31:0] tb_step(input bit [31:0] x);
        bit fb;
        fb = x[31] ^ x[30] ^ x[29] ^ x[27] ^ x[25] ^ x[0];
        return (x << 1) | {31'd0, fb};
    endfunction

    function automatic bit [31:0] sat(input bit [31:0] a, input int unsigned b);
        bit [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Behavioural model of the checker.
    bit          m_locked, m_err, m_have_prev;
    bit [31:0]   m_prev, m_ref, m_errc, m_bits, m_word;
    int unsigned m_match, m_miss;

    task automatic m_reset();
        m_locked = 0; m_err = 0; m_have_prev = 0;
        m_prev = 0; m_ref = 0; m_errc = 0; m_bits = 0; m_word = 0;
        m_match = 0; m_miss = 0;
    endtask

    task automatic model_update(input bit v, input bit [31:0] d, input bit c);
        bit bad;
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (m_have_prev && d == tb_step(m_prev) && d != 0) m_match++;
                else m_match = 0;
                m_prev = d;
                m_have_prev = 1;
                if (m_match >= LockCnt) begin
                    m_locked = 1; m_ref = tb_step(d); m_miss = 0; m_match = 0;
                end
            end else begin
                bad = (d != m_ref);
                m_err = bad;
                if (!c) begin
                    m_word = sat(m_word, 1);
                    if (bad) begin
                        m_errc = sat(m_errc, 1);
                        m_bits = sat(m_bits, $countones(d ^ m_ref));
                    end
                end
                m_ref = tb_step(m_ref);
                m_miss = bad ? m_miss + 1 : 0;
                if (m_miss >= UnlockCnt) begin
                    m_locked = 0; m_match = 0; m_prev = d; m_have_prev = 1; m_miss = 0;
                end
            end
        end
        if (c) begin
            m_errc = 0; m_bits = 0; m_word = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".locked"}, 32'(locked), 32'(m_locked));
        check({tag, ".err"}, 32'(err), 32'(m_err));
        check({tag, ".err_cnt"}, err_cnt, m_errc);
        check({tag, ".bit_err_cnt"}, bit_err_cnt, m_bits);
        check({tag, ".word_cnt"}, word_cnt, m_word);
    endtask

    task automatic apply(input bit v, input bit [31:0] d, input bit c, input string tag);
        valid = v; data_in = d; clear = c;
        @(posedge clk);
        model_update(v, d, c);
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset placed mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst.locked", 32'(locked), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.err_cnt", err_cnt, 32'd0);
        check("rst.bit_err_cnt", bit_err_cnt, 32'd0);
        check("rst.word_cnt", word_cnt, 32'd0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    bit [31:0] g;

    task automatic next_word(output bit [31:0] d);
        d = g;
        g = tb_step(g);
    endtask

    typedef struct {
        bit        v;
        bit [31:0] d;
        bit        c;
        bit        l;
        bit        e;
        bit [31:0] w;
    } vec_t;

    vec_t tbl[16];

    initial begin
        bit [31:0] w;
        int        nvalid;
        int        burst;

        tbl = '{
            '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0},
            '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'd0},
            '{1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'd0},
            '{1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 32'd0},
            '{1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 32'd0},
            '{1'b1, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 32'd0},
            '{1'b1, 32'h0000_001F, 1'b0, 1'b0, 1'b0, 32'd0},
            '{1'b1, 32'h0000_003F, 1'b0, 1'b0, 1'b0, 32'd0},
            '{1'b1, 32'h0000_007F, 1'b0, 1'b0, 1'b0, 32'd0},
            '{1'b1, 32'h0000_00FF, 1'b0, 1'b1, 1'b0, 32'd0},
            '{1'b1, 32'h0000_01FF, 1'b0, 1'b1, 1'b0, 32'd1},
            '{1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'd1},
            '{1'b1, 32'h0000_03DE, 1'b0, 1'b1, 1'b1, 32'd2},
            '{1'b1, 32'h0000_07FF, 1'b0, 1'b1, 1'b0, 32'd3},
            '{1'b1, 32'h0000_0FFE, 1'b1, 1'b1, 1'b1, 32'd0},
            '{1'b1, 32'h0000_1FFF, 1'b0, 1'b1, 1'b0, 32'd1}
        };

        rst = 1'b1; valid = 1'b0; data_in = '0; clear = 1'b0;
        m_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Vector table: zero and 0x80000000 lead-in, lock, skip, 2-bit error, clear.
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].c, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.locked", i), 32'(locked), 32'(tbl[i].l));
            check($sformatf("tbl%0d.err", i), 32'(err), 32'(tbl[i].e));
            check($sformatf("tbl%0d.word_cnt", i), word_cnt, tbl[i].w);
        end
        check("tbl.bit_err_cnt", bit_err_cnt, 32'd0);

        // Seed 1 stream with continuous valid.
        do_reset();
        g = 32'h1;
        for (int i = 0; i < 30; i++) begin
            next_word(w);
            apply(1'b1, w, 1'b0, "seed1");
            if (i == 7) check("lock_before_9th", 32'(locked), 32'd0);
            if (i == 8) check("lock_at_9th", 32'(locked), 32'd1);
        end
        check("seed1.word_cnt", word_cnt, 32'd21);

        // Four consecutive bad words drop lock; clean stream relocks after 9 words.
        for (int i = 0; i < 4; i++) begin
            next_word(w);
            apply(1'b1, w ^ 32'h10, 1'b0, "burst");
            if (i == 2) check("burst.still_locked", 32'(locked), 32'd1);
        end
        check("burst.unlocked", 32'(locked), 32'd0);
        check("burst.err_cnt", err_cnt, 32'd4);
        for (int i = 0; i < 20; i++) begin
            next_word(w);
            apply(1'b1, w, 1'b0, "relock");
            if (i == 7) check("relock.before", 32'(locked), 32'd0);
            if (i == 8) check("relock.after", 32'(locked), 32'd1);
        end

        // All-zero input never locks.
        do_reset();
        for (int i = 0; i < 100; i++) apply(1'b1, 32'h0, 1'b0, "zeros");
        check("zeros.locked", 32'(locked), 32'd0);

        // Valid every other cycle.
        do_reset();
        g = 32'h1;
        nvalid = 0;
        for (int i = 0; i < 60; i++) begin
            if (i % 2 == 0) begin
                next_word(w);
                apply(1'b1, w, 1'b0, "toggle");
                nvalid++;
                if (nvalid == 9) check("toggle.lock_at_9th", 32'(locked), 32'd1);
            end else begin
                apply(1'b0, $urandom, 1'b0, "toggle");
            end
        end
        check("toggle.err_cnt", err_cnt, 32'd0);

        // Three isolated errors, then asynchronous reset while locked.
        for (int i = 0; i < 6; i++) begin
            next_word(w);
            apply(1'b1, (i % 2 == 0) ? (w ^ 32'h8000_0000) : w, 1'b0, "err3");
        end
        check("err3.err_cnt", err_cnt, 32'd3);
        check("err3.locked", 32'(locked), 32'd1);
        do_reset();
        g = 32'h1234_5678;
        for (int i = 0; i < 12; i++) begin
            next_word(w);
            apply(1'b1, w, 1'b0, "after_rst");
        end
        check("after_rst.locked", 32'(locked), 32'd1);

        // Randomised stream: gaps, bit errors, bursts, clears and generator jumps.
        do_reset();
        g = $urandom | 32'h1;
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                next_word(w);
                if ($urandom_range(0, 299) == 0) burst = $urandom_range(1, 6);
                if (burst > 0) begin
                    w = w ^ ($urandom | 32'h1);
                    burst--;
                end else if ($urandom_range(0, 39) == 0) begin
                    w = w ^ ($urandom & $urandom);
                end
                if ($urandom_range(0, 499) == 0) g = $urandom;
                apply(1'b1, w, $urandom_range(0, 99) == 0, "rand");
            end else begin
                apply(1'b0, $urandom, $urandom_range(0, 99) == 0, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
